// File: rtl/pw_trigger_seq_pkg.sv
// Shared definitions for the trigger-sequence generator: state encodings
// and default field widths (kept in step with the register block).
package pw_trigger_seq_pkg;

    typedef enum logic [1:0] {
        PW_TS_IDLE  = 2'd0,
        PW_TS_DELAY = 2'd1,
        PW_TS_HIGH  = 2'd2,
        PW_TS_GAP   = 2'd3
    } pw_ts_state_e;

    localparam int PW_DELAY_WIDTH_DEF = 20;
    localparam int PW_WIDTH_WIDTH_DEF = 16;
    localparam int PW_COUNT_WIDTH_DEF = 8;
    localparam int PW_MISS_WIDTH_DEF  = 8;

endpackage

// File: rtl/pw_down_counter.sv
// Loadable down counter with a terminal-count flag. Load wins over enable,
// and the count holds at zero so it can never wrap.
module pw_down_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Count register: load, decrement toward zero, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_value;
        end else if (enable && (count_r != '0)) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == '0);

endmodule

// File: rtl/pw_trigger_seq.sv
// Trigger-sequence generator: on a rising match edge while armed, emits a
// train of pulses with programmable delay, pulse width, gap and count.
// Counters are loaded with (value - 1) so terminal count marks the last cycle.
module pw_trigger_seq
    import pw_trigger_seq_pkg::*;
#(
    parameter int pDELAY_WIDTH = PW_DELAY_WIDTH_DEF,
    parameter int pWIDTH_WIDTH = PW_WIDTH_WIDTH_DEF,
    parameter int pCOUNT_WIDTH = PW_COUNT_WIDTH_DEF,
    parameter int pMISS_WIDTH  = PW_MISS_WIDTH_DEF
) (
    input  logic                    trigger_clk,
    input  logic                    reset_n,
    input  logic                    I_arm,
    input  logic                    I_match,
    input  logic [pDELAY_WIDTH-1:0] I_delay,
    input  logic [pWIDTH_WIDTH-1:0] I_width,
    input  logic [pWIDTH_WIDTH-1:0] I_gap,
    input  logic [pCOUNT_WIDTH-1:0] I_num_pulses,
    input  logic                    I_oneshot,
    output logic                    O_trigger,
    output logic                    O_busy,
    output logic                    O_done,
    output logic [pMISS_WIDTH-1:0]  O_missed
);

    localparam logic [pDELAY_WIDTH-1:0] DELAY_ONE = {{(pDELAY_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [pWIDTH_WIDTH-1:0] WIDTH_ONE = {{(pWIDTH_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [pCOUNT_WIDTH-1:0] COUNT_ONE = {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [pMISS_WIDTH-1:0]  MISS_ONE  = {{(pMISS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [pMISS_WIDTH-1:0]  MISS_MAX  = '1;

    pw_ts_state_e             state_r;
    pw_ts_state_e             state_next_s;
    logic                     match_q_r;
    logic                     arm_q_r;
    logic                     trigger_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     spent_r;
    logic [pMISS_WIDTH-1:0]   missed_r;
    logic [pWIDTH_WIDTH-1:0]  width_sh_r;
    logic [pWIDTH_WIDTH-1:0]  gap_sh_r;

    logic                     edge_s;
    logic                     arm_rise_s;
    logic                     start_s;
    logic                     finish_s;
    logic                     miss_s;
    logic [pDELAY_WIDTH-1:0]  delay_m1_s;
    logic [pWIDTH_WIDTH-1:0]  width_m1_s;
    logic [pWIDTH_WIDTH-1:0]  gap_m1_s;
    logic [pCOUNT_WIDTH-1:0]  num_m1_s;

    logic                     delay_load_s;
    logic                     delay_en_s;
    logic                     delay_tc_s;
    logic                     wg_load_s;
    logic [pWIDTH_WIDTH-1:0]  wg_load_value_s;
    logic                     wg_en_s;
    logic                     wg_tc_s;
    logic                     pc_load_s;
    logic                     pc_en_s;
    logic                     pc_tc_s;

    // Zero-valued width/gap/count fields behave as one.
    assign delay_m1_s = I_delay - DELAY_ONE;
    assign width_m1_s = (I_width == '0)      ? '0 : (I_width - WIDTH_ONE);
    assign gap_m1_s   = (I_gap == '0)        ? '0 : (I_gap - WIDTH_ONE);
    assign num_m1_s   = (I_num_pulses == '0) ? '0 : (I_num_pulses - COUNT_ONE);

    assign edge_s     = I_match & ~match_q_r;
    assign arm_rise_s = I_arm & ~arm_q_r;
    assign start_s    = (state_r == PW_TS_IDLE) & edge_s & I_arm & ~spent_r;
    assign miss_s     = edge_s & ((state_r != PW_TS_IDLE) | spent_r);

    pw_down_counter #(.WIDTH(pDELAY_WIDTH)) u_delay_cnt (
        .clk(trigger_clk), .rst_n(reset_n), .load(delay_load_s),
        .load_value(delay_m1_s), .enable(delay_en_s), .tc(delay_tc_s)
    );

    pw_down_counter #(.WIDTH(pWIDTH_WIDTH)) u_wg_cnt (
        .clk(trigger_clk), .rst_n(reset_n), .load(wg_load_s),
        .load_value(wg_load_value_s), .enable(wg_en_s), .tc(wg_tc_s)
    );

    pw_down_counter #(.WIDTH(pCOUNT_WIDTH)) u_pulse_cnt (
        .clk(trigger_clk), .rst_n(reset_n), .load(pc_load_s),
        .load_value(num_m1_s), .enable(pc_en_s), .tc(pc_tc_s)
    );

    // Next-state decode and counter control; dropping arm aborts any train.
    always_comb begin
        state_next_s    = state_r;
        delay_load_s    = 1'b0;
        delay_en_s      = 1'b0;
        wg_load_s       = 1'b0;
        wg_load_value_s = width_sh_r;
        wg_en_s         = 1'b0;
        pc_load_s       = 1'b0;
        pc_en_s         = 1'b0;
        finish_s        = 1'b0;
        case (state_r)
            PW_TS_IDLE: begin
                if (start_s) begin
                    pc_load_s = 1'b1;
                    if (I_delay == '0) begin
                        state_next_s    = PW_TS_HIGH;
                        wg_load_s       = 1'b1;
                        wg_load_value_s = width_m1_s;
                    end else begin
                        state_next_s = PW_TS_DELAY;
                        delay_load_s = 1'b1;
                    end
                end else begin
                    state_next_s = PW_TS_IDLE;
                end
            end
            PW_TS_DELAY: begin
                if (!I_arm) begin
                    state_next_s = PW_TS_IDLE;
                end else if (delay_tc_s) begin
                    state_next_s    = PW_TS_HIGH;
                    wg_load_s       = 1'b1;
                    wg_load_value_s = width_sh_r;
                end else begin
                    delay_en_s = 1'b1;
                end
            end
            PW_TS_HIGH: begin
                if (!I_arm) begin
                    state_next_s = PW_TS_IDLE;
                end else if (wg_tc_s) begin
                    if (pc_tc_s) begin
                        state_next_s = PW_TS_IDLE;
                        finish_s     = 1'b1;
                    end else begin
                        state_next_s    = PW_TS_GAP;
                        wg_load_s       = 1'b1;
                        wg_load_value_s = gap_sh_r;
                        pc_en_s         = 1'b1;
                    end
                end else begin
                    wg_en_s = 1'b1;
                end
            end
            PW_TS_GAP: begin
                if (!I_arm) begin
                    state_next_s = PW_TS_IDLE;
                end else if (wg_tc_s) begin
                    state_next_s    = PW_TS_HIGH;
                    wg_load_s       = 1'b1;
                    wg_load_value_s = width_sh_r;
                end else begin
                    wg_en_s = 1'b1;
                end
            end
            default: begin
                state_next_s = PW_TS_IDLE;
            end
        endcase
    end

    // FSM state, registered outputs, spent flag and width/gap shadows.
    always_ff @(posedge trigger_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= PW_TS_IDLE;
            trigger_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            spent_r    <= 1'b0;
            width_sh_r <= '0;
            gap_sh_r   <= '0;
        end else begin
            state_r   <= state_next_s;
            trigger_r <= (state_next_s == PW_TS_HIGH);
            busy_r    <= (state_next_s != PW_TS_IDLE);
            done_r    <= finish_s;
            if (!I_arm) begin
                spent_r <= 1'b0;
            end else if (finish_s && I_oneshot) begin
                spent_r <= 1'b1;
            end else begin
                spent_r <= spent_r;
            end
            if (start_s) begin
                width_sh_r <= width_m1_s;
                gap_sh_r   <= gap_m1_s;
            end else begin
                width_sh_r <= width_sh_r;
                gap_sh_r   <= gap_sh_r;
            end
        end
    end

    // Match and arm history for edge detection.
    always_ff @(posedge trigger_clk or negedge reset_n) begin
        if (!reset_n) begin
            match_q_r <= 1'b0;
            arm_q_r   <= 1'b0;
        end else begin
            match_q_r <= I_match;
            arm_q_r   <= I_arm;
        end
    end

    // Saturating count of rejected match edges; re-arming clears it.
    always_ff @(posedge trigger_clk or negedge reset_n) begin
        if (!reset_n) begin
            missed_r <= '0;
        end else if (arm_rise_s) begin
            missed_r <= '0;
        end else if (miss_s && (missed_r != MISS_MAX)) begin
            missed_r <= missed_r + MISS_ONE;
        end else begin
            missed_r <= missed_r;
        end
    end

    assign O_trigger = trigger_r;
    assign O_busy    = busy_r;
    assign O_done    = done_r;
    assign O_missed  = missed_r;

endmodule

// File: tb/tb_pw_trigger_seq.sv
// Scoreboard bench for pw_trigger_seq. A timeline model of each pulse train
// produces per-cycle expected outputs; a negedge monitor compares them.
module tb_pw_trigger_seq;

    logic        clk;
    logic        reset_n;
    logic        arm;
    logic        match;
    logic [19:0] delay;
    logic [15:0] width;
    logic [15:0] gap;
    logic [7:0]  num;
    logic        oneshot;
    logic        trig_o;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  missed_o;

    pw_trigger_seq dut (
        .trigger_clk(clk), .reset_n(reset_n), .I_arm(arm), .I_match(match),
        .I_delay(delay), .I_width(width), .I_gap(gap), .I_num_pulses(num),
        .I_oneshot(oneshot), .O_trigger(trig_o), .O_busy(busy_o),
        .O_done(done_o), .O_missed(missed_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic       trig;
        logic       busy;
        logic       done;
        logic [7:0] missed;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, req);
        end
    endtask

    // Reference model: a train is a time window; trigger is high where the
    // offset into the train lands inside a pulse of its (W+G) period.
    int m_active, m_start, m_end, m_d, m_w, m_g, m_n, m_missed;
    bit m_spent, m_match_prev, m_arm_prev;

    task automatic model_reset();
        m_active = 0; m_start = 0; m_end = -1; m_d = 0; m_w = 1; m_g = 1; m_n = 1;
        m_missed = 0; m_spent = 0; m_match_prev = 0; m_arm_prev = 0;
    endtask

    function automatic bit trig_at(input int c);
        int off;
        if (c < m_start || c > m_end) return 1'b0;
        off = c - m_start - m_d;
        if (off < 0) return 1'b0;
        return ((off % (m_w + m_g)) < m_w);
    endfunction

    task automatic model_step();
        exp_t e;
        int   n;
        bit   edge_v, busy_v, start_v, done_v;
        n       = cyc;
        edge_v  = match && !m_match_prev;
        busy_v  = (m_active != 0);
        start_v = !busy_v && edge_v && arm && !m_spent;
        if (arm && !m_arm_prev) m_missed = 0;
        else if (edge_v && (busy_v || m_spent) && m_missed < 255) m_missed++;
        done_v = busy_v && arm && (n == m_end);
        if (!arm) m_spent = 0;
        else if (done_v && oneshot) m_spent = 1;
        if (busy_v && (!arm || n == m_end)) m_active = 0;
        if (start_v) begin
            m_d = int'(delay);
            m_w = (width == 16'd0) ? 1 : int'(width);
            m_g = (gap == 16'd0) ? 1 : int'(gap);
            m_n = (num == 8'd0) ? 1 : int'(num);
            m_start  = n + 1;
            m_end    = n + m_d + m_n * m_w + (m_n - 1) * m_g;
            m_active = 1;
        end
        e.cyc    = n + 1;
        e.trig   = (m_active != 0) ? trig_at(n + 1) : 1'b0;
        e.busy   = (m_active != 0);
        e.done   = done_v;
        e.missed = m_missed[7:0];
        q.push_back(e);
        m_match_prev = match;
        m_arm_prev   = arm;
    endtask

    // Monitor: pop the expectation for the current cycle and compare.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                chk("sb_stale", 32'(e.cyc), 32'(cyc));
            end else begin
                chk("trigger", {31'd0, trig_o}, {31'd0, e.trig});
                chk("busy", {31'd0, busy_o}, {31'd0, e.busy});
                chk("done", {31'd0, done_o}, {31'd0, e.done});
                chk("missed", {24'd0, missed_o}, {24'd0, e.missed});
            end
        end
    end

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic pulse_match();
        match = 1'b1; tick();
        match = 1'b0; tick();
    endtask

    task automatic set_cfg(input int d, input int w, input int g, input int n_p);
        delay = 20'(d); width = 16'(w); gap = 16'(g); num = 8'(n_p);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_trigger"}, {31'd0, trig_o}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_missed"}, {24'd0, missed_o}, 32'd0);
    endtask

    int busy_cnt;
    int done_cnt;

    initial begin
        reset_n = 1'b0; arm = 1'b0; match = 1'b0; oneshot = 1'b0;
        set_cfg(0, 1, 1, 1);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        arm = 1'b1;
        ticks(5);

        // Single minimal pulse.
        set_cfg(0, 1, 1, 1);
        pulse_match();
        ticks(8);

        // Delayed four-pulse train; count busy and done cycles directly.
        set_cfg(5, 3, 2, 4);
        match = 1'b1; tick();
        match = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            busy_cnt += int'(busy_o);
            done_cnt += int'(done_o);
            tick();
        end
        chk("train_busy_len", 32'(busy_cnt), 32'd23);
        chk("train_done_cnt", 32'(done_cnt), 32'd1);

        // Oneshot: second match rejected, re-arm clears missed and allows restart.
        oneshot = 1'b1;
        set_cfg(1, 2, 1, 2);
        pulse_match();
        ticks(98);
        pulse_match();
        ticks(10);
        chk("oneshot_missed", {24'd0, missed_o}, 32'd1);
        arm = 1'b0; ticks(2);
        arm = 1'b1; ticks(2);
        chk("rearm_missed", {24'd0, missed_o}, 32'd0);
        pulse_match();
        ticks(12);
        oneshot = 1'b0;
        arm = 1'b0; tick();
        arm = 1'b1; tick();

        // Long delay with a toggling match: missed saturates.
        set_cfg(700, 5, 3, 3);
        pulse_match();
        for (int i = 0; i < 600; i++) begin
            match = ~match;
            tick();
        end
        match = 1'b0;
        chk("missed_sat", {24'd0, missed_o}, 32'd255);
        ticks(140);

        // Abort by dropping arm during HIGH.
        set_cfg(2, 6, 2, 2);
        pulse_match();
        ticks(3);
        arm = 1'b0; ticks(3);
        arm = 1'b1; ticks(2);

        // Width change mid-train only affects the following train.
        set_cfg(1, 4, 2, 3);
        pulse_match();
        width = 16'd9; gap = 16'd0; num = 8'd0;
        ticks(25);
        pulse_match();
        ticks(15);

        // Async reset in GAP, then match held across release.
        set_cfg(0, 2, 6, 3);
        match = 1'b1; tick();
        ticks(3);
        #2;
        reset_n = 1'b0;
        q.delete();
        #1;
        check_all_zero("async_rst");
        arm = 1'b0; match = 1'b1;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_all_zero("rst_hold");
        reset_n = 1'b1;
        ticks(3);
        arm = 1'b1;
        ticks(20);
        match = 1'b0;
        ticks(2);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(63) == 0) arm = ~arm;
            match = ($urandom_range(3) == 0);
            if ($urandom_range(31) == 0) begin
                set_cfg($urandom_range(6), $urandom_range(4), $urandom_range(4), $urandom_range(4));
                oneshot = $urandom_range(1) == 1;
            end
            tick();
        end
        match = 1'b0;
        ticks(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
